// File: rtl/pipe_front.sv
// Front end of the pipeline: PC register, F/D and D/E pipeline registers with
// stall-driven hold and bubble insertion, plus a saturating stall-cycle counter.
module pipe_front #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      npc,
  input  logic [31:0]      F_instr,
  input  logic [31:0]      D_rs_data,
  input  logic [31:0]      D_rt_data,
  input  logic [31:0]      D_ext,
  input  logic [4:0]       D_A3,
  output logic [31:0]      F_pc,
  output logic [31:0]      D_pc,
  output logic [31:0]      D_instr,
  output logic [31:0]      E_pc,
  output logic [31:0]      E_instr,
  output logic [31:0]      E_rs_data,
  output logic [31:0]      E_rt_data,
  output logic [31:0]      E_ext,
  output logic [4:0]       E_A3,
  output logic [CNT_W-1:0] stall_cnt
);

  // PC and F/D freeze together so the stalled instruction waits in D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_pc    <= PC_RESET;
      D_pc    <= '0;
      D_instr <= '0;
    end else if (!stall) begin
      F_pc    <= npc;
      D_pc    <= F_pc;
      D_instr <= F_instr;
    end
  end

  // A bubble is an all-zero instruction with no destination, i.e. a nop.
  // E_pc still follows D_pc so the stalled instruction's PC stays visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_pc      <= '0;
      E_instr   <= '0;
      E_rs_data <= '0;
      E_rt_data <= '0;
      E_ext     <= '0;
      E_A3      <= '0;
    end else begin
      E_pc <= D_pc;
      if (stall) begin
        E_instr   <= '0;
        E_rs_data <= '0;
        E_rt_data <= '0;
        E_ext     <= '0;
        E_A3      <= '0;
      end else begin
        E_instr   <= D_instr;
        E_rs_data <= D_rs_data;
        E_rt_data <= D_rt_data;
        E_ext     <= D_ext;
        E_A3      <= D_A3;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_front.sv
// Directed bench for pipe_front: fetch sequencing, stall holds and bubbles,
// counter saturation and asynchronous reset behaviour.
module tb_pipe_front;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] npc;
  logic [31:0] F_instr;
  logic [31:0] D_rs_data;
  logic [31:0] D_rt_data;
  logic [31:0] D_ext;
  logic [4:0]  D_A3;
  logic [31:0] F_pc;
  logic [31:0] D_pc;
  logic [31:0] D_instr;
  logic [31:0] E_pc;
  logic [31:0] E_instr;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic [31:0] E_ext;
  logic [4:0]  E_A3;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  pipe_front #(.PC_RESET(32'h0000_3000), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .npc       (npc),
    .F_instr   (F_instr),
    .D_rs_data (D_rs_data),
    .D_rt_data (D_rt_data),
    .D_ext     (D_ext),
    .D_A3      (D_A3),
    .F_pc      (F_pc),
    .D_pc      (D_pc),
    .D_instr   (D_instr),
    .E_pc      (E_pc),
    .E_instr   (E_instr),
    .E_rs_data (E_rs_data),
    .E_rt_data (E_rt_data),
    .E_ext     (E_ext),
    .E_A3      (E_A3),
    .stall_cnt (stall_cnt)
  );

  // Clock and the sequential next-PC source: each instruction word is its own address.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    npc     = F_pc + 32'd4;
    F_instr = F_pc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_F_pc"},      F_pc,      32'h0000_3000);
    chk({tag, "_D_pc"},      D_pc,      32'h0);
    chk({tag, "_D_instr"},   D_instr,   32'h0);
    chk({tag, "_E_pc"},      E_pc,      32'h0);
    chk({tag, "_E_instr"},   E_instr,   32'h0);
    chk({tag, "_E_rs"},      E_rs_data, 32'h0);
    chk({tag, "_E_rt"},      E_rt_data, 32'h0);
    chk({tag, "_E_ext"},     E_ext,     32'h0);
    chk({tag, "_E_A3"},      {27'h0, E_A3}, 32'h0);
    chk({tag, "_stall_cnt"}, {16'h0, stall_cnt}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    stall     = 1'b0;
    D_rs_data = 32'h0;
    D_rt_data = 32'h0;
    D_ext     = 32'h0;
    D_A3      = 5'd0;
    #12;
    chk_reset_vals("rst");
    chk("rst_no_x", {31'h0, $isunknown({F_pc, D_pc, D_instr, E_pc, E_instr,
        E_rs_data, E_rt_data, E_ext, E_A3, stall_cnt})}, 32'h0);

    // Free-running fetch for three edges.
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("run1_F_pc",    F_pc,    32'h3004);
    chk("run1_D_instr", D_instr, 32'h3000);
    chk("run1_E_instr", E_instr, 32'h0);
    tick();
    tick();
    chk("run3_F_pc",    F_pc,    32'h300C);
    chk("run3_D_instr", D_instr, 32'h3008);
    chk("run3_D_pc",    D_pc,    32'h3008);
    chk("run3_E_instr", E_instr, 32'h3004);
    chk("run3_E_pc",    E_pc,    32'h3004);

    // Single-cycle stall at F_pc=0x3008; D operands nonzero to prove zeroing.
    do_reset();
    tick();
    tick();
    chk("s1_pre_F_pc",    F_pc,    32'h3008);
    chk("s1_pre_D_instr", D_instr, 32'h3004);
    D_A3      = 5'd3;
    D_rs_data = 32'h1111_1111;
    D_rt_data = 32'h2222_2222;
    D_ext     = 32'h3333_3333;
    stall     = 1'b1;
    tick();
    chk("s1_F_pc",    F_pc,      32'h3008);
    chk("s1_D_instr", D_instr,   32'h3004);
    chk("s1_D_pc",    D_pc,      32'h3004);
    chk("s1_E_instr", E_instr,   32'h0);
    chk("s1_E_A3",    {27'h0, E_A3}, 32'h0);
    chk("s1_E_rs",    E_rs_data, 32'h0);
    chk("s1_E_rt",    E_rt_data, 32'h0);
    chk("s1_E_ext",   E_ext,     32'h0);
    chk("s1_E_pc",    E_pc,      32'h3004);
    chk("s1_cnt",     {16'h0, stall_cnt}, 32'd1);
    stall = 1'b0;
    tick();
    chk("s1_rel_E_instr", E_instr, 32'h3004);
    chk("s1_rel_E_A3",    {27'h0, E_A3}, 32'd3);
    chk("s1_rel_E_rs",    E_rs_data, 32'h1111_1111);
    chk("s1_rel_F_pc",    F_pc,    32'h300C);
    chk("s1_rel_D_instr", D_instr, 32'h3008);

    // Two-cycle stall: two bubbles, then the held instruction and its successor.
    D_A3 = 5'd0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h3008);
    exp_q.push_back(32'h300C);
    stall = 1'b1;
    tick();
    chk("s2a_E_instr", E_instr, exp_q.pop_front());
    chk("s2a_E_pc",    E_pc,    32'h3008);
    chk("s2a_F_pc",    F_pc,    32'h300C);
    tick();
    chk("s2b_E_instr", E_instr, exp_q.pop_front());
    chk("s2b_F_pc",    F_pc,    32'h300C);
    chk("s2b_D_instr", D_instr, 32'h3008);
    chk("s2b_cnt",     {16'h0, stall_cnt}, 32'd3);
    stall = 1'b0;
    tick();
    chk("s2c_E_instr", E_instr, exp_q.pop_front());
    chk("s2c_D_instr", D_instr, 32'h300C);
    chk("s2c_cnt",     {16'h0, stall_cnt}, 32'd3);
    tick();
    chk("s2d_E_instr", E_instr, exp_q.pop_front());
    chk("s2d_F_pc",    F_pc,    32'h3014);

    // Operand transfer D -> E.
    D_A3      = 5'd8;
    D_rs_data = 32'hDEAD_BEEF;
    D_rt_data = 32'h1234_5678;
    D_ext     = 32'hFFFF_8000;
    tick();
    chk("op_E_A3",  {27'h0, E_A3}, 32'd8);
    chk("op_E_rs",  E_rs_data, 32'hDEAD_BEEF);
    chk("op_E_rt",  E_rt_data, 32'h1234_5678);
    chk("op_E_ext", E_ext,     32'hFFFF_8000);
    D_A3      = 5'd0;
    D_rs_data = 32'h0;
    D_rt_data = 32'h0;
    D_ext     = 32'h0;

    // Stall coincident with reset release: reset values held one extra cycle.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b1;
    tick();
    chk("rs_F_pc",    F_pc,    32'h3000);
    chk("rs_D_instr", D_instr, 32'h0);
    chk("rs_E_instr", E_instr, 32'h0);
    chk("rs_cnt",     {16'h0, stall_cnt}, 32'd1);
    stall = 1'b0;
    tick();
    chk("rs_rel_F_pc",    F_pc,    32'h3004);
    chk("rs_rel_D_instr", D_instr, 32'h3000);

    // Asynchronous reset between edges in the middle of a stall.
    stall = 1'b1;
    tick();
    chk("ar_pre_cnt", {16'h0, stall_cnt}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("ar");
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    tick();
    chk("ar_rel_F_pc",    F_pc,    32'h3004);
    chk("ar_rel_D_instr", D_instr, 32'h3000);

    // Long stall: counter reaches all-ones and holds there.
    do_reset();
    stall = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'h0, stall_cnt}, 32'h0000_FFFE);
    tick();
    chk("sat_ffff", {16'h0, stall_cnt}, 32'h0000_FFFF);
    repeat (4465) @(posedge clk);
    #1;
    chk("sat_hold",   {16'h0, stall_cnt}, 32'h0000_FFFF);
    chk("sat_F_pc",   F_pc,    32'h3000);
    chk("sat_E_instr", E_instr, 32'h0);
    stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_front.md
PIPE_FRONT -- requirements
Module: pipe_front

Interface
REQ-001 Parameter PC_RESET, 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter CNT_W, 16, width of stall-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 stall  input  1  hazard stall request from the stall unit, combinational in current cycle.
REQ-006 npc  input  32  next PC from next-PC logic.
REQ-007 F_instr  input  32  instruction fetched at F_pc.
REQ-008 D_rs_data  input  32  forwarded rs operand in D.
REQ-009 D_rt_data  input  32  forwarded rt operand in D.
REQ-010 D_ext  input  32  extended immediate in D.
REQ-011 D_A3  input  5  destination register decoded in D (0 = no write).
REQ-012 F_pc  output  32  current fetch PC.
REQ-013 D_pc, D_instr  output  32 each  F/D register contents.
REQ-014 E_pc, E_instr, E_rs_data, E_rt_data, E_ext  output  32 each  D/E register contents.
REQ-015 E_A3  output  5  D/E destination register.
REQ-016 stall_cnt  output  CNT_W  count of stalled cycles since reset.

Function
REQ-017 PC register: stall=0 -> F_pc <= npc; stall=1 -> F_pc holds.
REQ-018 F/D register: stall=0 -> D_pc <= F_pc, D_instr <= F_instr; stall=1 -> hold both.
REQ-019 D/E register: stall=0 -> all E_* <= corresponding D value (E_pc <= D_pc, E_instr <= D_instr).
REQ-020 D/E register: stall=1 -> bubble: E_instr, E_rs_data, E_rt_data, E_ext, E_A3 <= 0; E_pc <= D_pc (PC of stalled instruction, retained for debug).
REQ-021 Bubble (E_instr=0, E_A3=0) SHALL be indistinguishable from nop for downstream stages and the stall unit.
REQ-022 Latency: instruction at F_pc appears on D_instr 1 cycle later, on E_instr 2 cycles later, plus 1 cycle per stalled cycle while in D.
REQ-023 Consecutive stalls of N cycles: PC and F/D frozen N cycles, exactly N bubbles inserted, no instruction lost or duplicated.
REQ-024 stall_cnt increments by 1 on each rising edge with stall=1; saturates at all-ones (no wrap).
REQ-025 No state machine beyond the registers; stall has no effect on any register except as in REQ-017..024.
REQ-026 Branch delay slot: no flush logic; the instruction in F when a branch is in D proceeds normally.
REQ-027 stall asserted in the same cycle as reset deassertion: reset values held one more cycle, bubble enters E.

Reset
REQ-028 While reset=1 (asynchronous): F_pc = PC_RESET; D_pc, D_instr, E_pc, E_instr, E_rs_data, E_rt_data, E_ext = 0; E_A3 = 0; stall_cnt = 0.
REQ-029 Reset asserted mid-stall clears state immediately, independent of clk; after release, normal fetch starts from PC_RESET on next edge.
REQ-030 No output SHALL be X after reset assertion.

Verification
REQ-031 Reset then 3 edges, stall=0, npc=F_pc+4, F_instr=F_pc -> F_pc 0x300C, D_instr=0x3008, E_instr=0x3004.
REQ-032 At F_pc=0x3008 (D_instr=0x3004), assert stall 1 cycle -> F_pc stays 0x3008, D_instr stays 0x3004, E_instr=0, E_A3=0, E_pc=0x3004; next edge E_instr=0x3004.
REQ-033 stall held 2 cycles -> two bubbles in E, stall_cnt advances by 2, sequence resumes without loss or repeat.
REQ-034 stall held 70000 cycles with CNT_W=16 -> stall_cnt stops at 0xFFFF.
REQ-035 Assert reset asynchronously between edges during a stall -> all outputs at reset values before next edge; F_pc=0x3000.
REQ-036 stall=0, D_A3=5'd8, D_rs_data=32'hDEADBEEF -> next edge E_A3=8, E_rs_data=32'hDEADBEEF.
